fifo_ctrl: RTL

Pointer and flag controller for the UART TX/RX FIFOs. It sequences the dual-port register-file buffer: generates write/read addresses and the write enable, tracks full/empty, and rejects illegal pushes and pops. A FIFO top instantiates one `fifo_ctrl` beside one register-file buffer of matching `ADDR_WIDTH`; the UART receiver pushes and the transmitter or bus side pops.

---
 rtl/uart_fifo_pkg.sv | 14 +
 rtl/fifo_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and defaults for the UART FIFO controller and its register-file buffer top.
package uart_fifo_pkg;

  parameter int unsigned AddrWidthDefault = 3;

  // Request classes decoded from {wr, rd}.
  typedef enum logic [1:0] {
    OpNoop = 2'b00,
    OpRd   = 2'b01,
    OpWr   = 2'b10,
    OpWrRd = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and full/empty flag controller for a 2^ADDR_WIDTH-entry register-file FIFO.
// Define FIFO_CTRL_LEVEL_EN to build the level counter and the almost_full flag.
module fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDefault
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  parameter int unsigned ALMOST_FULL_LVL = 6
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
`endif
);

  fifo_op_e op;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  assign op = fifo_op_e'({wr, rd});

  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    unique case (op)
      OpWr: begin
        if (full_q) ovf_d = 1'b1;
        else        wr_acc = 1'b1;
      end
      OpRd: begin
        if (empty_q) unf_d = 1'b1;
        else         rd_acc = 1'b1;
      end
      OpWrRd: begin
        // At a boundary only the side that can make progress is accepted.
        if (empty_q) begin
          wr_acc = 1'b1;
          unf_d  = 1'b1;
        end else if (full_q) begin
          rd_acc = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          wr_acc = 1'b1;
          rd_acc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q + ADDR_WIDTH'(wr_acc);
    rptr_d  = rptr_q + ADDR_WIDTH'(rd_acc);
    full_d  = full_q;
    empty_d = empty_q;
    if (wr_acc && !rd_acc) begin
      empty_d = 1'b0;
      full_d  = (wptr_d == rptr_q);
    end else if (rd_acc && !wr_acc) begin
      full_d  = 1'b0;
      empty_d = (rptr_d == wptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign w_en      = wr & ~full_q;
  assign w_addr    = wptr_q;
  assign r_addr    = rptr_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef FIFO_CTRL_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AfLvl = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);

  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                af_q, af_d;

  always_comb begin
    level_d = level_q + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
    af_d    = (level_d >= AfLvl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign level       = level_q;
  assign almost_full = af_q;
`endif

endmodule
